// File: rtl/piece_spawner_pkg.sv
// Shared constants, colour codes and FSM encoding for the piece spawner.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package piece_spawner_pkg;

    // Grid memory layout. The spawn box must fit below the next-piece box:
    // SPAWN_BASE_ADDR + 3*GRID_COLS + 2 < NEXT_PIECE_BASE_ADDR.
    localparam logic [7:0] NEXT_PIECE_BASE_ADDR = 8'd240;
    localparam logic [7:0] GRID_COLS            = 8'd10;
    localparam logic [7:0] SPAWN_BASE_ADDR      = 8'd3;

    // Next-piece box geometry: 3 columns x 4 rows, offset = row*3 + col.
    localparam logic [3:0] BOX_COLS     = 4'd3;
    localparam logic [7:0] BOX_LAST_OFF = 8'd11;

    // A piece always occupies four cells.
    localparam int NUM_CELLS = 4;

    typedef logic [7:0] grid_addr_t;

    // Cell contents written into the grid; 0 means empty.
    typedef enum logic [7:0] {
        COLOUR_EMPTY = 8'd0,
        COLOUR_I     = 8'd1,
        COLOUR_O     = 8'd2,
        COLOUR_T     = 8'd3,
        COLOUR_S     = 8'd4,
        COLOUR_Z     = 8'd5,
        COLOUR_J     = 8'd6,
        COLOUR_L     = 8'd7
    } piece_colour_e;

    // One state per cycle: source read, four target reads, evaluate,
    // four writes, then park in DONE (or OVER after a collision).
    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_SRC  = 4'd1,
        ST_CHK0 = 4'd2,
        ST_CHK1 = 4'd3,
        ST_CHK2 = 4'd4,
        ST_CHK3 = 4'd5,
        ST_EVAL = 4'd6,
        ST_WR0  = 4'd7,
        ST_WR1  = 4'd8,
        ST_WR2  = 4'd9,
        ST_WR3  = 4'd10,
        ST_DONE = 4'd11,
        ST_OVER = 4'd12
    } spawn_state_e;

endpackage

// File: rtl/piece_spawner_if.sv
// Bundles the spawner's request, grid-memory and active-piece signals.
// Latency: n/a (wiring only).
// Backpressure: none; the game FSM holds en, the memory answers in a fixed cycle.
interface piece_spawner_if;
    import piece_spawner_pkg::*;

    // Request from the game FSM and the generator's next-piece cells.
    logic       en;
    grid_addr_t next_1_addr;
    grid_addr_t next_2_addr;
    grid_addr_t next_3_addr;
    grid_addr_t next_4_addr;

    // Grid memory port; rdata is valid one cycle after addr.
    logic       we;
    grid_addr_t addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    // Result towards the mover and game FSM.
    grid_addr_t active_1_addr;
    grid_addr_t active_2_addr;
    grid_addr_t active_3_addr;
    grid_addr_t active_4_addr;
    logic       spawned;
    logic       game_over;

    modport master (
        input  en,
        input  next_1_addr,
        input  next_2_addr,
        input  next_3_addr,
        input  next_4_addr,
        input  rdata,
        output we,
        output addr,
        output wdata,
        output active_1_addr,
        output active_2_addr,
        output active_3_addr,
        output active_4_addr,
        output spawned,
        output game_over
    );

    modport slave (
        output en,
        output next_1_addr,
        output next_2_addr,
        output next_3_addr,
        output next_4_addr,
        output rdata,
        input  we,
        input  addr,
        input  wdata,
        input  active_1_addr,
        input  active_2_addr,
        input  active_3_addr,
        input  active_4_addr,
        input  spawned,
        input  game_over
    );

endinterface

// File: rtl/piece_spawner_box_to_grid_addr.sv
// Maps a next-piece box address to its cell in the playfield spawn area.
// Latency: combinational.
// Backpressure: none.
module box_to_grid_addr
    import piece_spawner_pkg::*;
(
    input  grid_addr_t box_addr,
    output grid_addr_t grid_addr
);

    logic [7:0] off_raw;
    logic [3:0] off;
    logic [3:0] row;
    logic [3:0] col;

    // Out-of-box addresses fall back to offset 0 so a bad generator output
    // still lands on a legal spawn cell instead of scribbling elsewhere.
    always_comb begin
        off_raw = box_addr - NEXT_PIECE_BASE_ADDR;
        off     = 4'd0;
        if ((box_addr >= NEXT_PIECE_BASE_ADDR) && (off_raw <= BOX_LAST_OFF)) begin
            off = off_raw[3:0];
        end
        row       = off / BOX_COLS;
        col       = off % BOX_COLS;
        grid_addr = SPAWN_BASE_ADDR + ({4'd0, row} * GRID_COLS) + {4'd0, col};
    end

endmodule

// File: rtl/piece_spawner.sv
// Reads the next piece's colour, checks its four spawn cells, then writes it into the playfield.
// Latency: en seen at edge 0 -> writes in cycles 7..10, spawned pulse in cycle 11.
// Backpressure: none; dropping en aborts to IDLE at the next edge (except after game over).
module piece_spawner
    import piece_spawner_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    piece_spawner_if.master bus
);

    spawn_state_e state_q, state_d;
    grid_addr_t   addr_q, addr_d;
    logic         we_q, we_d;
    logic [7:0]   wdata_q, wdata_d;
    logic [7:0]   colour_q, colour_d;
    logic         hit_q, hit_d;
    logic         spawned_q, spawned_d;
    logic         game_over_q, game_over_d;

    grid_addr_t [NUM_CELLS-1:0] tgt_new;
    grid_addr_t [NUM_CELLS-1:0] tgt_q, tgt_d;
    grid_addr_t [NUM_CELLS-1:0] active_q, active_d;

    logic rd_occupied;

    // Translate each next-piece cell to its spawn target.
    box_to_grid_addr u_b2g_1 (.box_addr(bus.next_1_addr), .grid_addr(tgt_new[0]));
    box_to_grid_addr u_b2g_2 (.box_addr(bus.next_2_addr), .grid_addr(tgt_new[1]));
    box_to_grid_addr u_b2g_3 (.box_addr(bus.next_3_addr), .grid_addr(tgt_new[2]));
    box_to_grid_addr u_b2g_4 (.box_addr(bus.next_4_addr), .grid_addr(tgt_new[3]));

    assign rd_occupied = (bus.rdata != 8'd0);

    // State and registered outputs; reset drops we immediately, even mid-write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            colour_q    <= '0;
            hit_q       <= 1'b0;
            tgt_q       <= '0;
            active_q    <= '0;
            spawned_q   <= 1'b0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            colour_q    <= colour_d;
            hit_q       <= hit_d;
            tgt_q       <= tgt_d;
            active_q    <= active_d;
            spawned_q   <= spawned_d;
            game_over_q <= game_over_d;
        end
    end

    // Next state plus the values every registered output takes in that state.
    // Each read address is issued one state ahead of the state that consumes
    // its data, matching the memory's one-cycle read latency.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = 1'b0;
        wdata_d     = wdata_q;
        colour_d    = colour_q;
        hit_d       = hit_q;
        tgt_d       = tgt_q;
        active_d    = active_q;
        spawned_d   = 1'b0;
        game_over_d = game_over_q;

        if (!bus.en && (state_q != ST_IDLE) && (state_q != ST_OVER)) begin
            // Abort: nothing pending completes, active cells stay as they were.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.en && !game_over_q) begin
                        state_d = ST_SRC;
                        addr_d  = bus.next_1_addr;
                        tgt_d   = tgt_new;
                        hit_d   = 1'b0;
                    end
                end
                ST_SRC: begin
                    state_d = ST_CHK0;
                    addr_d  = tgt_q[0];
                end
                ST_CHK0: begin
                    // Data here is the next-piece box cell: the colour.
                    state_d  = ST_CHK1;
                    addr_d   = tgt_q[1];
                    colour_d = bus.rdata;
                end
                ST_CHK1: begin
                    state_d = ST_CHK2;
                    addr_d  = tgt_q[2];
                    hit_d   = hit_q | rd_occupied;
                end
                ST_CHK2: begin
                    state_d = ST_CHK3;
                    addr_d  = tgt_q[3];
                    hit_d   = hit_q | rd_occupied;
                end
                ST_CHK3: begin
                    state_d = ST_EVAL;
                    hit_d   = hit_q | rd_occupied;
                end
                ST_EVAL: begin
                    // Last target's data arrives now; fold it in before deciding.
                    if (hit_q || rd_occupied) begin
                        state_d     = ST_OVER;
                        hit_d       = 1'b1;
                        game_over_d = 1'b1;
                    end else begin
                        state_d = ST_WR0;
                        we_d    = 1'b1;
                        addr_d  = tgt_q[0];
                        wdata_d = colour_q;
                    end
                end
                ST_WR0: begin
                    state_d = ST_WR1;
                    we_d    = 1'b1;
                    addr_d  = tgt_q[1];
                end
                ST_WR1: begin
                    state_d = ST_WR2;
                    we_d    = 1'b1;
                    addr_d  = tgt_q[2];
                end
                ST_WR2: begin
                    state_d = ST_WR3;
                    we_d    = 1'b1;
                    addr_d  = tgt_q[3];
                end
                ST_WR3: begin
                    state_d   = ST_DONE;
                    active_d  = tgt_q;
                    spawned_d = 1'b1;
                end
                ST_DONE: begin
                    // Wait for en to fall so one request yields one spawn.
                    state_d = ST_DONE;
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.we            = we_q;
    assign bus.addr          = addr_q;
    assign bus.wdata         = wdata_q;
    assign bus.active_1_addr = active_q[0];
    assign bus.active_2_addr = active_q[1];
    assign bus.active_3_addr = active_q[2];
    assign bus.active_4_addr = active_q[3];
    assign bus.spawned       = spawned_q;
    assign bus.game_over     = game_over_q;

endmodule
